adc_frame_packetizer: RTL

Downstream consumer of the 10-channel ADC scan controller; takes each 80-bit scan frame (10 x 8-bit samples) on its valid pulse and serialises it into a 14-byte telemetry packet for the UART transmitter. It provides one pending-frame buffer, optional decimation, a packet sequence number, a checksum and a saturating drop counter. Its output is a byte valid/ready stream into the UART TX byte interface.

---
 rtl/adc_frame_packetizer_pkg.sv | 43 ++++
 rtl/adc_frame_packetizer_if.sv | 22 ++
 rtl/adc_frame_packetizer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/adc_frame_packetizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_packetizer_pkg
//  Purpose  : Shared definitions for the ADC frame packetizer and the
//             UART-side framing tool. Holds packet geometry, the default
//             sync bytes, the packetizer FSM state encoding and a helper
//             that picks one sample out of a scan frame.
//  Revision : 1.0  initial release
// ============================================================================
package adc_frame_packetizer_pkg;

    localparam int PKT_LEN  = 14;                 // SYNC0 SYNC1 SEQ D0..D9 CHK
    localparam int NUM_CH   = 10;
    localparam int SAMPLE_W = 8;
    localparam int FRAME_W  = NUM_CH * SAMPLE_W;

    localparam logic [SAMPLE_W-1:0] C_SYNC0_DEF = 8'hA5;
    localparam logic [SAMPLE_W-1:0] C_SYNC1_DEF = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC0 = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_SEQ   = 3'd3,
        ST_DATA  = 3'd4,
        ST_CHK   = 3'd5
    } state_t;

    // D0 sits in the top byte of the frame, D9 in the bottom byte.
    function automatic logic [SAMPLE_W-1:0] sample_at(
        input logic [FRAME_W-1:0] frame,
        input logic [3:0]         idx
    );
        sample_at = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == 4'(i)) begin
                sample_at = frame[(NUM_CH-1-i)*SAMPLE_W +: SAMPLE_W];
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_frame_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_packetizer_if
//  Purpose  : Byte valid/ready stream from the packetizer into the UART TX
//             byte interface.
//  Signals  : TX_DV    byte valid      (master -> slave)
//             TX_Byte  packet byte     (master -> slave)
//             TX_ready slave can take a byte this cycle (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface adc_frame_packetizer_if;
    import adc_frame_packetizer_pkg::*;

    logic                TX_DV;
    logic [SAMPLE_W-1:0] TX_Byte;
    logic                TX_ready;

    modport master (output TX_DV, output TX_Byte, input TX_ready);
    modport slave  (input  TX_DV, input  TX_Byte, output TX_ready);

endinterface
`default_nettype wire

// File: rtl/adc_frame_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_packetizer
//  Purpose  : Serialises 80-bit ADC scan frames into 14-byte telemetry
//             packets (SYNC0 SYNC1 SEQ D0..D9 CHK) with one pending-frame
//             buffer, input decimation, a sequence number, an additive
//             checksum and a saturating drop counter.
//  Ports    : i_clk         system clock
//             i_rst         asynchronous reset, active-low
//             i_ADC_valid   one-cycle frame strobe
//             i_ADC_data    scan frame, D0 in [79:72], D9 in [7:0]
//             tx            byte stream to the UART (master modport)
//             o_busy        packet in progress or pending frame held
//             o_drop_count  frames lost to overflow, saturates at 255
//  Revision : 1.0  initial release
// ============================================================================
module adc_frame_packetizer
    import adc_frame_packetizer_pkg::*;
#(
    parameter logic [7:0]  SYNC0 = C_SYNC0_DEF,
    parameter logic [7:0]  SYNC1 = C_SYNC1_DEF,
    parameter int unsigned DECIM = 1
)(
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    input  wire logic               i_ADC_valid,
    input  wire logic [FRAME_W-1:0] i_ADC_data,
    adc_frame_packetizer_if.master  tx,
    output logic                    o_busy,
    output logic [7:0]              o_drop_count
);

    localparam logic [7:0] C_DECIM_LAST = 8'(DECIM - 1);
    localparam logic [3:0] C_LAST_IDX   = 4'(NUM_CH - 1);

    state_t               r_state;
    logic [FRAME_W-1:0]   r_active;
    logic [FRAME_W-1:0]   r_pend;
    logic                 r_pend_full;
    logic [3:0]           r_idx;
    logic [7:0]           r_seq;
    logic [7:0]           r_chk;
    logic [7:0]           r_decim;
    logic [7:0]           r_drop;
    logic                 r_dv;
    logic [SAMPLE_W-1:0]  r_byte;

    logic w_xfer;
    logic w_accept;
    logic w_chk_xfer;
    logic w_pend_consume;
    logic w_direct_load;

    assign w_xfer         = r_dv & tx.TX_ready;
    assign w_accept       = i_ADC_valid & (r_decim == 8'd0);
    assign w_chk_xfer     = (r_state == ST_CHK) & w_xfer;
    assign w_pend_consume = w_chk_xfer & r_pend_full;
    // A frame accepted on the final CHK transfer with nothing pending is
    // launched straight into the active register; parking it in pending
    // would leave it stranded once the FSM drops to IDLE.
    assign w_direct_load  = w_chk_xfer & ~r_pend_full & w_accept;

    assign tx.TX_DV     = r_dv;
    assign tx.TX_Byte   = r_byte;
    assign o_busy       = (r_state != ST_IDLE) | r_pend_full;
    assign o_drop_count = r_drop;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_active    <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_idx       <= '0;
            r_seq       <= '0;
            r_chk       <= '0;
            r_decim     <= '0;
            r_drop      <= '0;
            r_dv        <= 1'b0;
            r_byte      <= '0;
        end else begin
            if (i_ADC_valid) begin
                r_decim <= (r_decim >= C_DECIM_LAST) ? 8'd0 : r_decim + 8'd1;
            end

            // Clear first so a same-cycle refill below keeps the flag set.
            if (w_pend_consume) begin
                r_pend_full <= 1'b0;
            end

            if (w_accept && (r_state != ST_IDLE) && !w_direct_load) begin
                if (!r_pend_full || w_pend_consume) begin
                    r_pend      <= i_ADC_data;
                    r_pend_full <= 1'b1;
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_active <= i_ADC_data;
                        r_state  <= ST_SYNC0;
                        r_dv     <= 1'b1;
                        r_byte   <= SYNC0;
                        r_chk    <= '0;
                    end
                end
                ST_SYNC0: begin
                    if (w_xfer) begin
                        r_state <= ST_SYNC1;
                        r_byte  <= SYNC1;
                    end
                end
                ST_SYNC1: begin
                    if (w_xfer) begin
                        r_state <= ST_SEQ;
                        r_byte  <= r_seq;
                    end
                end
                ST_SEQ: begin
                    if (w_xfer) begin
                        r_state <= ST_DATA;
                        r_idx   <= '0;
                        r_chk   <= r_chk + r_byte;
                        r_byte  <= sample_at(r_active, 4'd0);
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_chk <= r_chk + r_byte;
                        if (r_idx == C_LAST_IDX) begin
                            r_state <= ST_CHK;
                            r_byte  <= r_chk + r_byte;
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_byte <= sample_at(r_active, r_idx + 4'd1);
                        end
                    end
                end
                ST_CHK: begin
                    if (w_xfer) begin
                        r_seq <= r_seq + 8'd1;
                        if (r_pend_full || w_accept) begin
                            r_active <= r_pend_full ? r_pend : i_ADC_data;
                            r_state  <= ST_SYNC0;
                            r_byte   <= SYNC0;
                            r_chk    <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_dv    <= 1'b0;
                            r_byte  <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dv    <= 1'b0;
                    r_byte  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
